// File: rtl/uart_hex_ctrl.sv
`timescale 1ns/1ps
// uart_hex_ctrl
// Purpose: turns a stream of UART bytes into a 4-digit hex display word.
//   Hex characters are shifted into a staging register; CR commits the
//   staged digits to the display, ESC discards them, and space is ignored.
//   A partial entry left idle for TIMEOUT cycles is silently discarded.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, active low
//   rx_data  in   [7:0] received byte, stable while rx_flag is high
//   rx_flag  in   byte-complete flag, asynchronous to clk
//   data     out  [15:0] display word, [15:12] is the leftmost digit
//   digit_en out  [3:0] per-digit enable, bit i enables nibble i
//   updated  out  one-cycle pulse when data/digit_en are committed
//   err      out  one-cycle pulse when a byte is rejected
module uart_hex_ctrl #(
  parameter logic [15:0] RESET_WORD = 16'hAA00,
  parameter logic [23:0] TIMEOUT    = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  output logic [15:0] data,
  output logic [3:0]  digit_en,
  output logic        updated,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

  // flag synchronizer, edge detector and byte capture
  logic        r_sync1, r_sync2, r_sync3;
  logic        r_v1, r_v2, r_armed;
  logic        r_evt;
  logic [7:0]  r_byte;

  // entry state
  state_t      r_state, w_state_next;
  logic [15:0] r_stage, w_stage_next;
  logic [2:0]  r_count, w_count_next;
  logic [23:0] r_tmo,   w_tmo_next;

  // outputs
  logic [15:0] r_data,  w_data_next;
  logic [3:0]  r_en,    w_en_next;
  logic        r_upd,   w_upd_next;
  logic        r_err,   w_err_next;

  logic        w_rise;
  logic        w_is_hex;
  logic [3:0]  w_nib;
  logic [3:0]  w_mask;

  // r_armed only goes high once the synchronizer has carried a real low
  // sample of rx_flag; a flag already high when reset releases therefore
  // cannot masquerade as a rising edge against the cleared flops.
  assign w_rise = r_sync2 & ~r_sync3 & r_armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
      r_evt   <= 1'b0;
      r_byte  <= 8'h00;
      r_state <= IDLE;
      r_stage <= 16'h0000;
      r_count <= 3'd0;
      r_tmo   <= 24'd0;
      r_data  <= RESET_WORD;
      r_en    <= 4'b1111;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= rx_flag;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
      if (r_v2 && !r_sync2) r_armed <= 1'b1;
      r_evt   <= w_rise;
      if (w_rise) r_byte <= rx_data;
      r_state <= w_state_next;
      r_stage <= w_stage_next;
      r_count <= w_count_next;
      r_tmo   <= w_tmo_next;
      r_data  <= w_data_next;
      r_en    <= w_en_next;
      r_upd   <= w_upd_next;
      r_err   <= w_err_next;
    end
  end

  // byte classification: case-insensitive hex digit to nibble
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = r_byte[3:0];
    end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) ||
                 (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = r_byte[3:0] + 4'd9;
    end
  end

  // enable mask for a right-aligned entry of r_count digits
  always_comb begin
    w_mask = 4'b1111;
    case (r_count)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd3:    w_mask = 4'b0111;
      default: w_mask = 4'b1111;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_count_next = r_count;
    w_tmo_next   = r_tmo;
    w_data_next  = r_data;
    w_en_next    = r_en;
    w_upd_next   = 1'b0;
    w_err_next   = 1'b0;
    if (r_evt) begin
      // any byte restarts the idle timer and takes priority over expiry
      w_tmo_next = 24'd0;
      if (w_is_hex) begin
        if (r_state == FULL) begin
          w_err_next = 1'b1;
        end else begin
          w_stage_next = {r_stage[11:0], w_nib};
          w_count_next = r_count + 3'd1;
          w_state_next = (r_count == 3'd3) ? FULL : ENTRY;
        end
      end else begin
        case (r_byte)
          8'h0D: begin
            if (r_state == IDLE) begin
              w_err_next = 1'b1;
            end else begin
              w_data_next  = r_stage;
              w_en_next    = w_mask;
              w_upd_next   = 1'b1;
              w_stage_next = 16'h0000;
              w_count_next = 3'd0;
              w_state_next = IDLE;
            end
          end
          8'h1B: begin
            w_stage_next = 16'h0000;
            w_count_next = 3'd0;
            w_state_next = IDLE;
          end
          8'h20: ;
          default: w_err_next = 1'b1;
        endcase
      end
    end else if (r_state != IDLE) begin
      if (r_tmo == TIMEOUT - 24'd1) begin
        w_stage_next = 16'h0000;
        w_count_next = 3'd0;
        w_state_next = IDLE;
        w_tmo_next   = 24'd0;
      end else begin
        w_tmo_next = r_tmo + 24'd1;
      end
    end
  end

  assign data     = r_data;
  assign digit_en = r_en;
  assign updated  = r_upd;
  assign err      = r_err;

endmodule

// File: tb/tb_uart_hex_ctrl.sv
`timescale 1ns/1ps
module tb_uart_hex_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic [15:0] data;
  logic [3:0]  digit_en;
  logic        updated;
  logic        err;

  always #5 clk = ~clk;

  uart_hex_ctrl #(
    .RESET_WORD(16'hAA00),
    .TIMEOUT   (24'd40)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_flag (rx_flag),
    .data    (data),
    .digit_en(digit_en),
    .updated (updated),
    .err     (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;

  // reference model: byte-level rules, each byte takes effect on the
  // fourth edge counting the first edge that samples its flag high
  logic [15:0] m_data, m_stage;
  logic [3:0]  m_en;
  logic        m_upd, m_err;
  int          m_cnt;
  int          m_last;
  int          due_q[$];
  logic [7:0]  byte_q[$];

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int v;
    v = hex_val(b);
    if (v >= 0) begin
      if (m_cnt < 4) begin
        m_stage = 16'((int'(m_stage) * 16 + v) % 65536);
        m_cnt   = m_cnt + 1;
      end else begin
        m_err = 1'b1;
      end
    end else if (b == 8'h0D) begin
      if (m_cnt == 0) m_err = 1'b1;
      else begin
        m_data  = m_stage;
        m_en    = 4'((1 << m_cnt) - 1);
        m_upd   = 1'b1;
        m_stage = 16'h0;
        m_cnt   = 0;
      end
    end else if (b == 8'h1B) begin
      m_stage = 16'h0;
      m_cnt   = 0;
    end else if (b != 8'h20) begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [7:0] b;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_data  = 16'hAA00;
      m_en    = 4'b1111;
      m_stage = 16'h0;
      m_cnt   = 0;
      m_last  = n_edge;
      due_q.delete();
      byte_q.delete();
    end else if (due_q.size() > 0 && due_q[0] == n_edge) begin
      void'(due_q.pop_front());
      b = byte_q.pop_front();
      model_byte(b);
      m_last = n_edge;
    end else if (m_cnt >= 1 && n_edge - m_last == TO) begin
      m_stage = 16'h0;
      m_cnt   = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n_edge, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    model_edge();
    @(negedge clk);
    chk("data",     data,             m_data);
    chk("digit_en", {12'h0, digit_en}, {12'h0, m_en});
    chk("updated",  {15'h0, updated},  {15'h0, m_upd});
    chk("err",      {15'h0, err},      {15'h0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    rx_data = b;
    rx_flag = 1'b1;
    due_q.push_back(n_edge + 4);
    byte_q.push_back(b);
    $display("[TB] byte %h due at edge %0d", b, n_edge + 4);
    idle(hi);
    rx_flag = 1'b0;
    idle(lo);
  endtask

  task automatic send_s(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 5, 4);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
    idle(5);
  endtask

  initial begin
    string hexs;
    int    sel, target, lo;
    logic [7:0] b;
    hexs    = "0123456789ABCDEFabcdef";
    rst_n   = 1'b0;
    rx_flag = 1'b0;
    rx_data = 8'h00;
    m_data  = 16'hAA00;
    m_en    = 4'b1111;
    m_stage = 16'h0;
    m_cnt   = 0;
    m_last  = 0;
    m_upd   = 1'b0;
    m_err   = 1'b0;
    do_reset(3);
    idle(10);

    // commit of a full 4-digit entry, mixed case
    send_s("1aF3");
    send(8'h0D, 5, 4);
    chk("full_commit", data, 16'h1AF3);
    // two digits then a lone CR
    send_s("7B");
    send(8'h0D, 5, 4);
    chk("two_digit", data, 16'h007B);
    send(8'h0D, 5, 4);
    // overflow digit
    send_s("12345");
    send(8'h0D, 5, 4);
    chk("overflow", data, 16'h1234);
    // timeout discard then CR rejected
    send_s("9");
    idle(TO + 10);
    send(8'h0D, 5, 4);
    // CR processed in the exact expiry cycle wins
    send_s("9");
    target = m_last + TO - 4;
    if (n_edge > target) begin
      n_tests++;
      n_fail++;
      $display("FAIL expiry_align: edge %0d past target %0d", n_edge, target);
    end
    while (n_edge < target) tick();
    send(8'h0D, 5, 4);
    chk("expiry_cr", data, 16'h0009);
    // invalid byte, cancel, new entry
    send_s("5G");
    send(8'h1B, 5, 4);
    send_s("C");
    send(8'h0D, 5, 4);
    chk("cancel", data, 16'h000C);
    // space is ignored
    send_s("4 2");
    send(8'h0D, 5, 4);
    chk("space", data, 16'h0042);
    // reset mid-entry discards staging
    send_s("5");
    do_reset(2);
    send(8'h0D, 5, 4);
    chk("reset_mid", data, 16'hAA00);
    // flag already high across reset release creates no event
    rx_data = "7";
    rx_flag = 1'b1;
    rst_n   = 1'b0;
    idle(3);
    rst_n   = 1'b1;
    idle(8);
    rx_flag = 1'b0;
    idle(6);
    send(8'h0D, 5, 4);

    // randomized byte stream
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4) b = hexs[$urandom_range(0, 21)];
      else if (sel == 5 || sel == 9) b = 8'h0D;
      else if (sel == 6) b = 8'h1B;
      else if (sel == 7) b = 8'h20;
      else b = 8'($urandom);
      lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 50))
                                       : int'($urandom_range(3, 8));
      send(b, int'($urandom_range(4, 7)), lo);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
